duram_port_arb: RTL and testbench

DURAM_PORT_ARB -- requirements
Module: duram_port_arb

---
 rtl/duram_port_arb.sv | 128 ++++++++++++
 tb/tb_duram_port_arb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/duram_port_arb.sv
// Two-requester arbiter for a single-port RAM with registered read data.
// Bounded-burst fairness: the owner keeps the port for up to MAX_BURST grants while the other waits.
module duram_port_arb #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int MAX_BURST  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic                  ram_wren,
   input  logic [DATA_WIDTH-1:0] ram_q
);

   // state | meaning
   // IDLE  | no owner; ties go to the requester not served last
   // OWN0  | requester 0 won the previous cycle, r_cnt counts its burst
   // OWN1  | requester 1 won the previous cycle, r_cnt counts its burst
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

   state_t     r_state, w_state_nxt;
   logic [3:0] r_cnt, w_cnt_nxt;
   logic       r_last, w_last_nxt;
   logic       r_rvalid0, r_rvalid1;
   logic       w_win_vld, w_win, w_is_owner;
   logic       w_gnt0, w_gnt1;

   always_comb begin
      w_win_vld = 1'b0;
      w_win     = 1'b0;
      case (r_state)
         OWN0: begin
            if (req0 && (!req1 || r_cnt < MAX_CNT)) begin
               w_win_vld = 1'b1;
               w_win     = 1'b0;
            end else if (req1) begin
               w_win_vld = 1'b1;
               w_win     = 1'b1;
            end
         end
         OWN1: begin
            if (req1 && (!req0 || r_cnt < MAX_CNT)) begin
               w_win_vld = 1'b1;
               w_win     = 1'b1;
            end else if (req0) begin
               w_win_vld = 1'b1;
               w_win     = 1'b0;
            end
         end
         default: begin
            if (req0 && req1) begin
               w_win_vld = 1'b1;
               w_win     = ~r_last;
            end else if (req0) begin
               w_win_vld = 1'b1;
               w_win     = 1'b0;
            end else if (req1) begin
               w_win_vld = 1'b1;
               w_win     = 1'b1;
            end
         end
      endcase
   end

   // Grants are masked while reset is held so the RAM sees no access in that cycle.
   assign w_gnt0     = rst_n & w_win_vld & ~w_win;
   assign w_gnt1     = rst_n & w_win_vld & w_win;
   assign w_is_owner = ((r_state == OWN0) && !w_win) || ((r_state == OWN1) && w_win);

   always_comb begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = 4'd0;
      w_last_nxt  = r_last;
      if (w_win_vld) begin
         w_state_nxt = w_win ? OWN1 : OWN0;
         w_last_nxt  = w_win;
         if (w_is_owner) begin
            w_cnt_nxt = (r_cnt < MAX_CNT) ? r_cnt + 4'd1 : r_cnt;
         end else begin
            w_cnt_nxt = 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= 4'd0;
         r_last    <= 1'b1;
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_last    <= w_last_nxt;
         r_rvalid0 <= w_gnt0 & ~we0;
         r_rvalid1 <= w_gnt1 & ~we1;
      end
   end

   assign gnt0     = w_gnt0;
   assign gnt1     = w_gnt1;
   assign ram_addr = w_win ? addr1 : addr0;
   assign ram_data = w_win ? wdata1 : wdata0;
   assign ram_wren = (w_gnt0 & we0) | (w_gnt1 & we1);
   assign rvalid0  = r_rvalid0 & rst_n;
   assign rvalid1  = r_rvalid1 & rst_n;
   assign rdata0   = ram_q;
   assign rdata1   = ram_q;

endmodule

// File: tb/tb_duram_port_arb.sv
// Bench for duram_port_arb: directed scenarios plus random traffic against a rule-level arbiter and memory model.
module tb_duram_port_arb;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic          gnt0, gnt1, rvalid0, rvalid1, ram_wren;
   logic [DW-1:0] rdata0, rdata1, ram_data, ram_q;
   logic [AW-1:0] ram_addr;

   logic          a_gnt0, a_gnt1, a_rv0, a_rv1, a_wren;
   logic [DW-1:0] a_rd0, a_rd1, a_data;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_q = '0;

   always #5 clk = ~clk;

   duram_port_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q));

   // Second instance with single-grant bursts, fed the same requests
   duram_port_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(1)) u_alt (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt0(a_gnt0), .gnt1(a_gnt1), .rvalid0(a_rv0), .rvalid1(a_rv1),
      .rdata0(a_rd0), .rdata1(a_rd1),
      .ram_addr(a_addr), .ram_data(a_data), .ram_wren(a_wren), .ram_q(a_q));

   // Attached RAM: registered read, write takes effect at the edge
   logic [DW-1:0] mem [32];
   always @(posedge clk) begin
      if (ram_wren) mem[ram_addr] <= ram_data;
      ram_q <= mem[ram_addr];
   end

   int n_assert = 0;
   int n_fail   = 0;

   // reference model state
   int            m_owner = -1;
   int            m_cnt   = 0;
   int            m_last  = 1;
   int            m_w     = -1;
   bit            m_pend [2];
   bit            m_pval [2];
   logic [DW-1:0] m_pdata [2];
   logic [DW-1:0] ref_mem [32];
   bit            ref_ok [32];
   int            waitc [2];
   bit            alt_on = 0;
   int            alt_exp = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks the settled outputs for this cycle, then advances the model past the coming edge.
   task automatic eval();
      int w;
      bit rq [2];
      bit wq [2];
      logic [AW-1:0] aq [2];
      logic [DW-1:0] dq [2];
      #1;
      rq[0] = req0; rq[1] = req1; wq[0] = we0; wq[1] = we1;
      aq[0] = addr0; aq[1] = addr1; dq[0] = wdata0; dq[1] = wdata1;
      w = -1;
      if (rst_n) begin
         if (m_owner >= 0) begin
            if (rq[m_owner] && (!rq[1-m_owner] || m_cnt < MB)) w = m_owner;
            else if (rq[1-m_owner]) w = 1 - m_owner;
         end else if (rq[0] && rq[1]) w = 1 - m_last;
         else if (rq[0]) w = 0;
         else if (rq[1]) w = 1;
      end
      chk("gnt0", gnt0, w == 0);
      chk("gnt1", gnt1, w == 1);
      chk("ram_wren", ram_wren, (w >= 0) ? wq[w] : 1'b0);
      if (w >= 0) begin
         chk("ram_addr", ram_addr, aq[w]);
         chk("ram_data", ram_data, dq[w]);
      end
      chk("rvalid0", rvalid0, m_pend[0] && rst_n);
      chk("rvalid1", rvalid1, m_pend[1] && rst_n);
      if (m_pend[0] && rst_n && m_pval[0]) chk("rdata0", rdata0, m_pdata[0]);
      if (m_pend[1] && rst_n && m_pval[1]) chk("rdata1", rdata1, m_pdata[1]);
      if (alt_on && rst_n) begin
         chk("alt_gnt0", a_gnt0, alt_exp == 0);
         chk("alt_gnt1", a_gnt1, alt_exp == 1);
         alt_exp = 1 - alt_exp;
      end
      if (rst_n) begin
         waitc[0] = (req0 && !gnt0) ? waitc[0] + 1 : 0;
         waitc[1] = (req1 && !gnt1) ? waitc[1] + 1 : 0;
         if (waitc[0] > 0) chk("wait0_bound", waitc[0] <= MB, 1'b1);
         if (waitc[1] > 0) chk("wait1_bound", waitc[1] <= MB, 1'b1);
      end else begin
         waitc[0] = 0; waitc[1] = 0;
      end
      if (!rst_n) begin
         m_owner = -1; m_cnt = 0; m_last = 1;
         m_pend[0] = 0; m_pend[1] = 0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            m_pend[i]  = (w == i) && !wq[i];
            m_pdata[i] = ref_mem[aq[i]];
            m_pval[i]  = ref_ok[aq[i]];
         end
         if (w >= 0) begin
            if (wq[w]) begin
               ref_mem[aq[w]] = dq[w];
               ref_ok[aq[w]]  = 1;
            end
            m_cnt   = (w == m_owner) ? ((m_cnt < MB) ? m_cnt + 1 : m_cnt) : 1;
            m_owner = w;
            m_last  = w;
         end else begin
            m_owner = -1; m_cnt = 0;
         end
      end
      m_w = w;
   endtask

   task automatic drive(input bit rs, input bit r0, input bit w0, input int a0, input logic [DW-1:0] d0,
                        input bit r1, input bit w1, input int a1, input logic [DW-1:0] d1);
      @(negedge clk);
      rst_n = rs;
      req0 = r0; we0 = w0; addr0 = AW'(a0); wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = AW'(a1); wdata1 = d1;
      eval();
   endtask

   initial begin
      int seq [10];
      seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
      for (int i = 0; i < 32; i++) ref_ok[i] = 0;

      // reset held with both requesting, then requester 0 wins the first tie
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 1, '0, 1, 0, 2, '0);
      drive(1, 1, 0, 1, '0, 1, 0, 2, '0);
      chk("first_tie_gnt0", gnt0, 1'b1);

      // requester 0 alone: write then read back the same address
      drive(1, 1, 1, 5, 32'hA5A5A5A5, 0, 0, 0, '0);
      drive(1, 1, 0, 5, '0, 0, 0, 0, '0);
      chk("rd_gnt0", gnt0, 1'b1);
      drive(1, 0, 0, 0, '0, 0, 0, 0, '0);
      chk("rd_rvalid0", rvalid0, 1'b1);
      chk("rd_rdata0", rdata0, 32'hA5A5A5A5);

      // continuous contention: bursts of four; single-grant instance alternates
      drive(0, 1, 0, 5, '0, 1, 0, 5, '0);
      alt_on = 1; alt_exp = 0;
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, 0, 5, '0, 1, 0, 5, '0);
         chk("burst_seq", gnt1, seq[i][0]);
      end
      alt_on = 0;

      // owner drops mid-burst: immediate handover
      drive(0, 0, 0, 0, '0, 0, 0, 0, '0);
      drive(1, 1, 0, 1, '0, 0, 0, 0, '0);
      drive(1, 1, 0, 1, '0, 1, 0, 2, '0);
      drive(1, 0, 0, 1, '0, 1, 0, 2, '0);
      chk("handover_gnt1", gnt1, 1'b1);
      drive(1, 0, 0, 0, '0, 0, 0, 0, '0);
      chk("cnt_after_handover", u_dut.r_cnt, 64'd1);

      // reset during a read grant leaves no rvalid; first tie then goes to 0
      drive(1, 0, 0, 0, '0, 1, 0, 3, '0);
      drive(0, 0, 0, 0, '0, 1, 0, 3, '0);
      drive(1, 1, 0, 3, '0, 1, 0, 3, '0);
      chk("post_rst_gnt0", gnt0, 1'b1);
      chk("post_rst_no_rv1", rvalid1, 1'b0);

      // random traffic; requests held until granted
      drive(0, 0, 0, 0, '0, 0, 0, 0, '0);
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         rst_n = 1'b1;
         if (!req0 || m_w == 0) begin
            req0 = ($urandom_range(0, 9) < 7); we0 = 1'($urandom_range(0, 1));
            addr0 = AW'($urandom_range(0, 7)); wdata0 = $urandom;
         end
         if (!req1 || m_w == 1) begin
            req1 = ($urandom_range(0, 9) < 7); we1 = 1'($urandom_range(0, 1));
            addr1 = AW'($urandom_range(0, 7)); wdata1 = $urandom;
         end
         eval();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
